// File: rtl/caliptra_sram_rmw_ctrl.sv
// Single-outstanding request/response front end for a single-port SRAM without byte enables.
// Partial-strobe writes become read-modify-write; out-of-range addresses get an error response.
module caliptra_sram_rmw_ctrl #(
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
   parameter int unsigned NUM_BYTES  = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_BYTES-1:0]  req_wstrb_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  sram_cs_o,
   output logic                  sram_we_o,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_wdata_o,
   input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

   generate
      if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
         $error("DATA_WIDTH must be a multiple of 8");
      end
      if (DEPTH < 2) begin : g_bad_depth
         $error("DEPTH must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD      = 3'd1,
      S_RD_DATA = 3'd2,
      S_WR      = 3'd3,
      S_RSP     = 3'd4
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [NUM_BYTES-1:0]  r_wstrb;
   logic [DATA_WIDTH-1:0] r_wdata;

   logic                  r_req_ready;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;
   logic                  r_sram_cs;
   logic                  r_sram_we;
   logic [ADDR_WIDTH-1:0] r_sram_addr;
   logic [DATA_WIDTH-1:0] r_sram_wdata;

   logic                  w_accept;
   logic                  w_rsp_done;
   logic                  w_addr_oob;
   logic                  w_strb_full;
   logic                  w_strb_zero;
   logic                  w_nxt_access;
   logic [DATA_WIDTH-1:0] w_merged;

   assign w_accept     = req_valid_i & r_req_ready;
   assign w_rsp_done   = r_rsp_valid & rsp_ready_i;
   assign w_addr_oob   = (32'(req_addr_i) >= DEPTH);
   assign w_strb_full  = &req_wstrb_i;
   assign w_strb_zero  = ~|req_wstrb_i;
   assign w_nxt_access = (w_state_nxt == S_RD) || (w_state_nxt == S_WR);

   // Strobed bytes come from the captured request, the rest from the word just read
   always_comb begin
      w_merged = sram_rdata_i;
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
         if (r_wstrb[b]) begin
            w_merged[8*b +: 8] = r_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_addr_oob || (req_write_i && w_strb_zero)) begin
                  w_state_nxt = S_RSP;
               end else if (req_write_i && w_strb_full) begin
                  w_state_nxt = S_WR;
               end else begin
                  w_state_nxt = S_RD;
               end
            end
         end
         S_RD:      w_state_nxt = S_RD_DATA;
         S_RD_DATA: w_state_nxt = r_write ? S_WR : S_RSP;
         S_WR:      w_state_nxt = S_RSP;
         S_RSP: begin
            if (w_rsp_done) begin
               w_state_nxt = S_IDLE;
            end
         end
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Captured request; req_* may change freely after the accept edge
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wstrb <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_write <= req_write_i;
         r_addr  <= req_addr_i;
         r_wstrb <= req_wstrb_i;
         r_wdata <= req_wdata_i;
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_req_ready  <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_rsp_rdata  <= '0;
         r_rsp_err    <= 1'b0;
         r_sram_cs    <= 1'b0;
         r_sram_we    <= 1'b0;
         r_sram_addr  <= '0;
         r_sram_wdata <= '0;
      end else begin
         r_req_ready <= (w_state_nxt == S_IDLE);
         r_rsp_valid <= (w_state_nxt == S_RSP);
         r_sram_cs   <= w_nxt_access;
         r_sram_we   <= (w_state_nxt == S_WR);

         if (w_nxt_access) begin
            r_sram_addr <= (r_state == S_IDLE) ? req_addr_i : r_addr;
         end

         if (w_state_nxt == S_WR) begin
            r_sram_wdata <= (r_state == S_IDLE) ? req_wdata_i : w_merged;
         end else begin
            r_sram_wdata <= '0;
         end

         if (w_accept) begin
            r_rsp_err <= w_addr_oob;
         end else if (w_rsp_done) begin
            r_rsp_err <= 1'b0;
         end

         if ((r_state == S_RD_DATA) && !r_write) begin
            r_rsp_rdata <= sram_rdata_i;
         end else if (w_accept || w_rsp_done) begin
            r_rsp_rdata <= '0;
         end
      end
   end

   assign req_ready_o  = r_req_ready;
   assign rsp_valid_o  = r_rsp_valid;
   assign rsp_rdata_o  = r_rsp_rdata;
   assign rsp_err_o    = r_rsp_err;
   assign sram_cs_o    = r_sram_cs;
   assign sram_we_o    = r_sram_we;
   assign sram_addr_o  = r_sram_addr;
   assign sram_wdata_o = r_sram_wdata;

endmodule

// File: tb/tb_caliptra_sram_rmw_ctrl.sv
// Randomized bench for caliptra_sram_rmw_ctrl: SRAM emulation plus a latency-table reference model
// compared against every DUT output on each falling edge.
module tb_caliptra_sram_rmw_ctrl;

   localparam int unsigned DEPTH = 48;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 6;
   localparam int unsigned NB    = 4;
   localparam int unsigned MEMW  = 64;

   localparam int K_RD   = 0;
   localparam int K_FULL = 1;
   localparam int K_PART = 2;
   localparam int K_NOP  = 3;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic          req_write_i;
   logic [AW-1:0] req_addr_i;
   logic [NB-1:0] req_wstrb_i;
   logic [DW-1:0] req_wdata_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [DW-1:0] rsp_rdata_o;
   logic          rsp_err_o;
   logic          sram_cs_o;
   logic          sram_we_o;
   logic [AW-1:0] sram_addr_o;
   logic [DW-1:0] sram_wdata_o;
   logic [DW-1:0] sram_rdata_i;

   int vectors     = 0;
   int miscompares = 0;

   caliptra_sram_rmw_ctrl #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_BYTES  (NB)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_write_i  (req_write_i),
      .req_addr_i   (req_addr_i),
      .req_wstrb_i  (req_wstrb_i),
      .req_wdata_i  (req_wdata_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_err_o    (rsp_err_o),
      .sram_cs_o    (sram_cs_o),
      .sram_we_o    (sram_we_o),
      .sram_addr_o  (sram_addr_o),
      .sram_wdata_o (sram_wdata_o),
      .sram_rdata_i (sram_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] seed_word(int i);
      return ((32'(i) + 32'd1) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] s);
      logic [31:0] m;
      m = 32'd0;
      for (int b = 0; b < 4; b++) begin
         m = m | ((s[b] ? new_w : old_w) & (32'hFF << (8 * b)));
      end
      return m;
   endfunction

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
      end
   endfunction

   // SRAM macro emulation: one-cycle read latency, garbage on rdata otherwise
   logic          mem_load;
   logic [DW-1:0] sram_mem [MEMW];
   always @(posedge clk_i) begin
      if (mem_load) begin
         for (int i = 0; i < int'(MEMW); i++) sram_mem[i] <= seed_word(i);
      end else if (sram_cs_o && sram_we_o) begin
         sram_mem[sram_addr_o] <= sram_wdata_o;
      end
      if (sram_cs_o && !sram_we_o) sram_rdata_i <= sram_mem[sram_addr_o];
      else sram_rdata_i <= $urandom;
   end

   // Reference model: transaction kind + cycles since accept -> expected pins
   logic [DW-1:0] ref_mem [MEMW];
   bit            m_busy;
   int            m_k, m_lat, m_kind;
   bit            m_err;
   logic [AW-1:0] m_addr, m_last_addr;
   logic [DW-1:0] m_wdata;
   logic [NB-1:0] m_strb;
   bit            e_cs, e_we, e_valid;
   logic [DW-1:0] e_wdata, e_rdata;
   logic [AW-1:0] e_addr;

   initial begin
      for (int i = 0; i < int'(MEMW); i++) ref_mem[i] = seed_word(i);
      m_busy = 0; m_k = 0; m_lat = 0; m_kind = K_NOP; m_err = 0;
      m_addr = '0; m_last_addr = '0; m_wdata = '0; m_strb = '0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            check("rst_req_ready", 32'(req_ready_o), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
            check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
            check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
            check("rst_sram_cs", 32'(sram_cs_o), 32'd0);
            check("rst_sram_we", 32'(sram_we_o), 32'd0);
            check("rst_sram_addr", 32'(sram_addr_o), 32'd0);
            check("rst_sram_wdata", sram_wdata_o, 32'd0);
            m_busy = 0;
            m_last_addr = '0;
         end else begin
            e_valid = m_busy && (m_k >= m_lat);
            e_cs = m_busy && ((m_k == 1 && m_kind != K_NOP) || (m_k == 3 && m_kind == K_PART));
            e_we = m_busy && ((m_k == 1 && m_kind == K_FULL) || (m_k == 3 && m_kind == K_PART));
            e_wdata = !e_we ? 32'd0 :
                      (m_kind == K_FULL) ? m_wdata : merge(ref_mem[m_addr], m_wdata, m_strb);
            e_addr  = e_cs ? m_addr : m_last_addr;
            e_rdata = (m_kind == K_RD) ? ref_mem[m_addr] : 32'd0;

            check("req_ready", 32'(req_ready_o), 32'(!m_busy));
            check("rsp_valid", 32'(rsp_valid_o), 32'(e_valid));
            check("sram_cs", 32'(sram_cs_o), 32'(e_cs));
            check("sram_we", 32'(sram_we_o), 32'(e_we));
            check("sram_addr", 32'(sram_addr_o), 32'(e_addr));
            check("sram_wdata", sram_wdata_o, e_wdata);
            if (e_valid) begin
               check("rsp_rdata", rsp_rdata_o, e_rdata);
               check("rsp_err", 32'(rsp_err_o), 32'(m_err));
            end

            if (e_cs) m_last_addr = m_addr;
            if (e_we) ref_mem[m_addr] = e_wdata;
            if (!m_busy) begin
               if (req_valid_i) begin
                  m_busy = 1; m_k = 1; m_err = 0;
                  m_addr = req_addr_i; m_wdata = req_wdata_i; m_strb = req_wstrb_i;
                  if (32'(req_addr_i) >= DEPTH) begin
                     m_kind = K_NOP; m_lat = 1; m_err = 1;
                  end else if (!req_write_i) begin
                     m_kind = K_RD; m_lat = 3;
                  end else if (req_wstrb_i == 4'h0) begin
                     m_kind = K_NOP; m_lat = 1;
                  end else if (req_wstrb_i == 4'hF) begin
                     m_kind = K_FULL; m_lat = 2;
                  end else begin
                     m_kind = K_PART; m_lat = 4;
                  end
               end
            end else if (e_valid) begin
               if (rsp_ready_i) m_busy = 0;
            end else begin
               m_k++;
            end
         end
      end
   end

   task automatic scramble_req();
      req_write_i = 1'($urandom_range(1));
      req_addr_i  = AW'($urandom_range(63));
      req_wstrb_i = NB'($urandom_range(15));
      req_wdata_i = $urandom;
   endtask

   // Drives a request, waits for accept; returns at posedge+1 of the first post-accept cycle
   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [NB-1:0] s,
                        input logic [DW-1:0] d);
      int n;
      req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_wstrb_i = s; req_wdata_i = d;
      n = 0;
      @(negedge clk_i);
      while (!req_ready_o && n < 40) begin
         @(negedge clk_i);
         n++;
      end
      check("accept_in_budget", 32'(req_ready_o), 32'd1);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      scramble_req();
   endtask

   task automatic txn(input logic w, input logic [AW-1:0] a, input logic [NB-1:0] s,
                      input logic [DW-1:0] d, input int dly,
                      output logic [DW-1:0] rd, output logic er, output int lat);
      int  vcnt;
      bit  done;
      rd = '0; er = 1'b0; lat = -1; vcnt = 0; done = 0;
      rsp_ready_i = (dly == 0);
      issue(w, a, s, d);
      for (int c = 1; c <= 60 && !done; c++) begin
         @(negedge clk_i);
         if (rsp_valid_o) begin
            if (vcnt == 0) lat = c;
            vcnt++;
            if (rsp_ready_i) begin
               rd = rsp_rdata_o;
               er = rsp_err_o;
               done = 1;
            end
         end
         @(posedge clk_i); #1;
         rsp_ready_i = (vcnt >= dly);
      end
      rsp_ready_i = 1'b0;
      check("rsp_in_budget", 32'(done), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] rd;
      logic          er;
      int            lat;
      logic          w;
      logic [AW-1:0] a;
      logic [NB-1:0] s;

      rst_i = 1'b1; mem_load = 1'b1; rsp_ready_i = 1'b0;
      req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 6'd5;
      req_wstrb_i = 4'hF; req_wdata_i = 32'h0BAD_0BAD;
      repeat (3) @(posedge clk_i);
      #1;
      mem_load = 1'b0; rst_i = 1'b0; req_valid_i = 1'b0;
      @(posedge clk_i); #1;

      txn(1'b1, 6'd5, 4'hF, 32'hDEAD_BEEF, 0, rd, er, lat);
      check("full_wr_lat", 32'(lat), 32'd2);
      txn(1'b0, 6'd5, 4'h0, 32'h0, 2, rd, er, lat);
      check("rd5_lat", 32'(lat), 32'd3);
      check("rd5_data", rd, 32'hDEAD_BEEF);

      txn(1'b1, 6'd7, 4'hF, 32'h1122_3344, 1, rd, er, lat);
      txn(1'b1, 6'd7, 4'h5, 32'hAABB_CCDD, 0, rd, er, lat);
      check("rmw_lat", 32'(lat), 32'd4);
      check("rmw_rsp_rdata", rd, 32'd0);
      txn(1'b0, 6'd7, 4'h0, 32'h0, 0, rd, er, lat);
      check("rmw_readback", rd, 32'h11BB_33DD);

      txn(1'b1, 6'd3, 4'h0, 32'hFFFF_FFFF, 0, rd, er, lat);
      check("zero_strb_lat", 32'(lat), 32'd1);
      check("zero_strb_err", 32'(er), 32'd0);
      txn(1'b0, 6'd3, 4'h0, 32'h0, 0, rd, er, lat);
      check("zero_strb_keep", rd, seed_word(3));

      txn(1'b0, 6'd50, 4'h0, 32'h0, 0, rd, er, lat);
      check("oob_lat", 32'(lat), 32'd1);
      check("oob_err", 32'(er), 32'd1);
      check("oob_rdata", rd, 32'd0);
      txn(1'b1, 6'd48, 4'hF, 32'h1234_5678, 1, rd, er, lat);
      check("oob_wr_err", 32'(er), 32'd1);

      txn(1'b0, 6'd7, 4'h0, 32'h0, 5, rd, er, lat);
      check("held_rsp_data", rd, 32'h11BB_33DD);

      // Reset lands in the write cycle of a read-modify-write
      txn(1'b1, 6'd9, 4'hF, 32'hCAFE_F00D, 0, rd, er, lat);
      issue(1'b1, 6'd9, 4'h3, 32'h1234_5678);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      check("rmw_wr_cs", 32'(sram_cs_o), 32'd1);
      rst_i = 1'b1;
      #1;
      check("rst_drops_cs", 32'(sram_cs_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      txn(1'b0, 6'd9, 4'h0, 32'h0, 0, rd, er, lat);
      check("rst_no_commit", rd, 32'hCAFE_F00D);

      for (int t = 0; t < 300; t++) begin
         w = 1'($urandom_range(1));
         a = AW'($urandom_range(63));
         case ($urandom_range(3))
            0:       s = 4'h0;
            1:       s = 4'hF;
            default: s = NB'($urandom_range(15));
         endcase
         txn(w, a, s, $urandom, int'($urandom_range(3)), rd, er, lat);
         repeat ($urandom_range(2)) begin
            @(posedge clk_i); #1;
         end
      end

      repeat (3) @(posedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/caliptra_sram_rmw_ctrl.md
Name: caliptra_sram_rmw_ctrl

Overview:
Request/response front end that sits directly upstream of the single-port SRAM macro wrapper. It drives that wrapper's cs/we/addr/wdata pins and consumes its rdata. The SRAM has no byte enables, so partial-strobe writes are converted into a read-modify-write sequence. One transaction is outstanding at a time, and out-of-range addresses are rejected with an error response.

Parameters:
DEPTH, 64, number of SRAM words; any value >= 2, not necessarily a power of two
DATA_WIDTH, 32, word width in bits; must be a multiple of 8 (elaboration error otherwise)
ADDR_WIDTH, $clog2(DEPTH), word address width
NUM_BYTES, DATA_WIDTH/8, derived; strobe width

Ports:
clk_i  in  1  clock; all logic on posedge
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready; high only in IDLE
req_write_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_WIDTH  word address
req_wstrb_i  in  NUM_BYTES  byte strobes; bit i covers wdata[8i+7:8i]; ignored for reads
req_wdata_i  in  DATA_WIDTH  write data
rsp_valid_o  out  1  response valid; held until rsp_ready_i
rsp_ready_i  in  1  response accepted
rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err_o  out  1  address >= DEPTH; no SRAM access was made
sram_cs_o  out  1  SRAM chip select (registered)
sram_we_o  out  1  SRAM write enable (registered)
sram_addr_o  out  ADDR_WIDTH  SRAM address (registered)
sram_wdata_o  out  DATA_WIDTH  SRAM write data (registered); 0 when sram_we_o=0
sram_rdata_i  in  DATA_WIDTH  SRAM read data; valid the cycle after a read-select cycle

Behaviour:
- Reset (async assert, sync-safe deassert by the integrator): state IDLE. req_ready_o=1 while in IDLE out of reset; every other output is 0. The captured request is discarded. The async clear drops sram_cs_o immediately, so an in-flight SRAM write is not committed.
- Handshake: a request is accepted on a cycle T with req_valid_i & req_ready_o. All req_* fields are captured at that edge and may change afterwards. A response completes on rsp_valid_o & rsp_ready_i; IDLE is entered on the following cycle.
- States: IDLE, RD, RD_DATA, WR, RSP. sram_cs_o is high only in RD and WR.
- Address check at accept: if addr >= DEPTH, go IDLE->RSP with rsp_err_o=1, no SRAM access, rsp_valid_o at T+1. This check applies to both reads and writes.
- Read: IDLE->RD (cs=1, we=0, T+1) ->RD_DATA (capture sram_rdata_i into rsp_rdata_o, T+2) ->RSP. rsp_valid_o at T+3.
- Full-strobe write (all ones): IDLE->WR (cs=1, we=1, wdata=req data, T+1) ->RSP. rsp_valid_o at T+2.
- Partial-strobe write: IDLE->RD (T+1) ->RD_DATA (T+2), where merged = strobed bytes from request, others from sram_rdata_i ->WR (T+3, merged data) ->RSP. rsp_valid_o at T+4.
- Zero-strobe write: IDLE->RSP, no SRAM access, rsp_valid_o at T+1, rsp_err_o=0.
- RSP: rsp_valid_o, rsp_rdata_o and rsp_err_o stay stable until the handshake. rsp_ready_i may be high before rsp_valid_o rises; the handshake then completes on the first RSP cycle.
- No request is accepted in any state except IDLE. Because there is no pipelining, RAW hazards cannot occur. Throughput is at most one transaction per latency+1 cycles.
- Outside RD/WR: sram_we_o=0 and sram_wdata_o=0. sram_addr_o holds its last value.

Test Plan:
- Reset with req_valid_i=1 held: all outputs 0 except req_ready_o=1; no sram_cs_o pulse until after rst_i deasserts.
- Full write addr 5 data 0xDEADBEEF strobe 0xF accepted at T -> cs/we high with addr 5 at T+1, rsp_valid at T+2; then read addr 5 -> rsp_rdata 0xDEADBEEF at T+3.
- Preload addr 7 = 0x11223344, write strobe 0x5 data 0xAABBCCDD -> read cycle then write cycle of 0x11BB33DD at T+3, rsp_valid at T+4; readback gives 0x11BB33DD.
- Strobe 0x0 write to addr 3 -> rsp_valid at T+1, no cs activity, addr 3 contents unchanged.
- DEPTH=48 instance, read of addr 50 -> rsp_err_o=1, rsp_rdata_o=0 at T+1, no cs activity.
- Hold rsp_ready_i=0 for 5 cycles after a read -> rsp fields stable, req_ready_o=0 throughout. Also assert rst_i during the WR cycle of an RMW -> cs drops immediately and a readback shows the old data.
